// File: rtl/mine_field_gen.sv
// Minefield generator: LFSR rejection-sampled mines, then 8-neighbour counts.
// Optional MINE_FIELD_GEN_SAFE_FIRST_EN keeps the latched safe_index tile mine-free.
module mine_field_gen #(
  parameter int          GRID_SIZE = 5,
  parameter int          NUM_MINES = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int TOTAL_TILES = GRID_SIZE * GRID_SIZE,
  localparam int INDEX_BITS  =
    (TOTAL_TILES > 1) ? $clog2(TOTAL_TILES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [INDEX_BITS-1:0]    safe_index,
  output logic [TOTAL_TILES-1:0]   mine_map,
  output logic [4*TOTAL_TILES-1:0] adj,
  output logic                     busy,
  output logic                     ready
);

  localparam int COORD_BITS =
    (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1;
  localparam int PC_BITS   = $clog2(NUM_MINES + 1);
  localparam int PAD_TILES = 1 << INDEX_BITS;

  if (NUM_MINES < 1 || NUM_MINES >= TOTAL_TILES) begin : g_bad_mines
    $error("NUM_MINES must be in 1..TOTAL_TILES-1");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("LFSR_SEED must be non-zero");
  end
  if (TOTAL_TILES > 32) begin : g_bad_grid
    $error("TOTAL_TILES must not exceed 32");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLACE,
    S_COUNT,
    S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [15:0]              lfsr_q, lfsr_d;
  logic [TOTAL_TILES-1:0]   mine_map_q, mine_map_d;
  logic [4*TOTAL_TILES-1:0] adj_q, adj_d;
  logic                     busy_q, busy_d;
  logic                     ready_q, ready_d;
  logic [PC_BITS-1:0]       placed_q, placed_d;
  logic [INDEX_BITS-1:0]    tile_q, tile_d;
  logic [COORD_BITS-1:0]    x_q, x_d;
  logic [COORD_BITS-1:0]    y_q, y_d;

  logic                  fb;
  logic [INDEX_BITS-1:0] cand;
  logic [PAD_TILES-1:0]  map_pad;
  logic                  accept;
  logic [3:0]            nsum;

  assign fb      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign cand    = lfsr_q[INDEX_BITS-1:0];
  assign map_pad = PAD_TILES'(mine_map_q);

`ifdef MINE_FIELD_GEN_SAFE_FIRST_EN
  logic [INDEX_BITS-1:0] safe_q, safe_d;

  always_comb begin
    accept = (int'(cand) < TOTAL_TILES) && !map_pad[cand] &&
             (cand != safe_q);
  end
`else
  logic unused_safe_index;

  assign unused_safe_index = ^safe_index;

  always_comb begin
    accept = (int'(cand) < TOTAL_TILES) && !map_pad[cand];
  end
`endif

  // Off-grid neighbours are skipped, so edges and corners see fewer tiles.
  always_comb begin
    int nx;
    int ny;
    nsum = 4'd0;
    nx   = 0;
    ny   = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(x_q) + dx;
        ny = int'(y_q) + dy;
        if ((dx != 0 || dy != 0) &&
            nx >= 0 && nx < GRID_SIZE &&
            ny >= 0 && ny < GRID_SIZE) begin
          nsum = nsum +
            {3'b000, map_pad[INDEX_BITS'(ny * GRID_SIZE + nx)]};
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = {lfsr_q[14:0], fb};
    mine_map_d = mine_map_q;
    adj_d      = adj_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    placed_d   = placed_q;
    tile_d     = tile_q;
    x_d        = x_q;
    y_d        = y_q;
`ifdef MINE_FIELD_GEN_SAFE_FIRST_EN
    safe_d     = safe_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_PLACE;
          mine_map_d = '0;
          adj_d      = '0;
          busy_d     = 1'b1;
          ready_d    = 1'b0;
          placed_d   = '0;
          tile_d     = '0;
          x_d        = '0;
          y_d        = '0;
`ifdef MINE_FIELD_GEN_SAFE_FIRST_EN
          safe_d     = safe_index;
`endif
        end
      end
      S_PLACE: begin
        if (accept) begin
          mine_map_d = mine_map_q | (TOTAL_TILES'(1) << cand);
          placed_d   = placed_q + PC_BITS'(1);
          if (placed_q == PC_BITS'(NUM_MINES - 1)) begin
            state_d = S_COUNT;
          end
        end
      end
      S_COUNT: begin
        for (int i = 0; i < TOTAL_TILES; i++) begin
          if (tile_q == INDEX_BITS'(i)) begin
            adj_d[i*4 +: 4] = nsum;
          end
        end
        if (tile_q == INDEX_BITS'(TOTAL_TILES - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          tile_d = tile_q + INDEX_BITS'(1);
          if (x_q == COORD_BITS'(GRID_SIZE - 1)) begin
            x_d = '0;
            y_d = y_q + COORD_BITS'(1);
          end else begin
            x_d = x_q + COORD_BITS'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= LFSR_SEED;
      mine_map_q <= '0;
      adj_q      <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      placed_q   <= '0;
      tile_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
`ifdef MINE_FIELD_GEN_SAFE_FIRST_EN
      safe_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      mine_map_q <= mine_map_d;
      adj_q      <= adj_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      placed_q   <= placed_d;
      tile_q     <= tile_d;
      x_q        <= x_d;
      y_q        <= y_d;
`ifdef MINE_FIELD_GEN_SAFE_FIRST_EN
      safe_q     <= safe_d;
`endif
    end
  end

  assign mine_map = mine_map_q;
  assign adj      = adj_q;
  assign busy     = busy_q;
  assign ready    = ready_q;

endmodule
